// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the 32-bit ALU: one-entry valid/ready register
// with beq/bne/jr resolution and a registered fetch redirect.
module alu_issue_stage #(
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic        flush_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [3:0]  alu_operation_o,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [4:0]  shamt_o,
  output logic [4:0]  rd_addr_o,
  output logic        reg_write_o,
  output logic        illegal_o,
  input  logic        alu_zero_i,
  input  logic [31:0] alu_result_i,
  output logic        redirect_o,
  output logic [31:0] redirect_target_o
);

  localparam logic [3:0] OP_SUB = 4'b0000;
  localparam logic [3:0] OP_SRL = 4'b0001;
  localparam logic [3:0] OP_LUI = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_JR  = 4'b0111;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
    logic        beq;
    logic        bne;
    logic        jr;
    logic [31:0] tgt;
  } ent_t;

  logic [5:0]  w_opc;
  logic [5:0]  w_fn;
  logic [15:0] w_imm;
  logic [31:0] w_sext;
  logic [31:0] w_zext;
  logic        w_rt;
  logic        w_add, w_sub, w_sll, w_srl, w_jr;
  logic        w_addi, w_ori, w_lui, w_beq, w_bne;
  logic        w_keep;
  ent_t        w_ent;

  assign w_opc  = instr_i[31:26];
  assign w_fn   = instr_i[5:0];
  assign w_imm  = instr_i[15:0];
  assign w_sext = {{16{w_imm[15]}}, w_imm};
  assign w_zext = {16'h0000, w_imm};
  assign w_rt   = (w_opc == 6'b000000);

  assign w_add  = w_rt & (w_fn == 6'b100000);
  assign w_sub  = w_rt & (w_fn == 6'b100010);
  assign w_sll  = w_rt & (w_fn == 6'b000000);
  assign w_srl  = w_rt & (w_fn == 6'b000010);
  assign w_jr   = w_rt & (w_fn == 6'b001000);
  assign w_addi = (w_opc == 6'b001000);
  assign w_ori  = (w_opc == 6'b001101);
  assign w_lui  = (w_opc == 6'b001111);
  assign w_beq  = (w_opc == 6'b000100);
  assign w_bne  = (w_opc == 6'b000101);

  always_comb begin
    w_ent       = '0;
    w_ent.op    = OP_ADD;
    w_ent.a     = rs_data_i;
    w_ent.b     = rt_data_i;
    w_ent.tgt   = pc_plus4_i + {w_sext[29:0], 2'b00};
    w_keep      = 1'b1;
    unique case (1'b1)
      w_add, w_sub, w_sll, w_srl: begin
        w_ent.op    = w_add ? OP_ADD :
                      w_sub ? OP_SUB :
                      w_sll ? OP_SLL : OP_SRL;
        w_ent.rd    = instr_i[15:11];
        w_ent.shamt = instr_i[10:6];
        w_ent.rw    = 1'b1;
      end
      w_jr: begin
        w_ent.op = OP_JR;
        w_ent.jr = 1'b1;
      end
      w_addi: begin
        w_ent.b  = w_sext;
        w_ent.rd = instr_i[20:16];
        w_ent.rw = 1'b1;
      end
      w_ori, w_lui: begin
        w_ent.op = w_ori ? OP_OR : OP_LUI;
        w_ent.b  = w_zext;
        w_ent.rd = instr_i[20:16];
        w_ent.rw = 1'b1;
      end
      w_beq, w_bne: begin
        w_ent.op  = OP_SUB;
        w_ent.beq = w_beq;
        w_ent.bne = w_bne;
      end
      default: begin
        w_ent.ill = 1'b1;
        w_keep    = ILLEGAL_AS_NOP;
      end
    endcase
  end

  ent_t        r_ent;
  logic        r_valid;
  logic        r_redirect;
  logic [31:0] r_redirect_tgt;

  logic w_fire;
  logic w_taken;
  logic w_accept;

  assign instr_ready_o = !r_valid | ex_ready_i;
  assign w_fire  = r_valid & ex_ready_i;
  assign w_taken = w_fire & !flush_i &
                   ((r_ent.beq & alu_zero_i) |
                    (r_ent.bne & !alu_zero_i) |
                    r_ent.jr);
  // Wrong-path instructions are handshaken but never enter the register.
  assign w_accept = instr_valid_i & instr_ready_o & w_keep &
                    !flush_i & !w_taken & !r_redirect;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ent          <= '0;
      r_valid        <= 1'b0;
      r_redirect     <= 1'b0;
      r_redirect_tgt <= '0;
    end else begin
      if (flush_i)
        r_valid <= 1'b0;
      else if (w_accept)
        r_valid <= 1'b1;
      else if (w_fire)
        r_valid <= 1'b0;
      if (w_accept)
        r_ent <= w_ent;
      r_redirect <= w_taken;
      if (w_taken)
        r_redirect_tgt <= r_ent.jr ? alu_result_i : r_ent.tgt;
    end
  end

  assign ex_valid_o        = r_valid;
  assign alu_operation_o   = r_ent.op;
  assign a_o               = r_ent.a;
  assign b_o               = r_ent.b;
  assign shamt_o           = r_ent.shamt;
  assign rd_addr_o         = r_ent.rd;
  assign reg_write_o       = r_ent.rw;
  assign illegal_o         = r_ent.ill;
  assign redirect_o        = r_redirect;
  assign redirect_target_o = r_redirect_tgt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, handshake, branch
// resolution, squash, flush, illegal handling and async reset.
module tb_alu_issue_stage;

  logic        clk;
  logic        reset;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_plus4_i;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic        flush_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [3:0]  alu_operation_o;
  logic [31:0] a_o;
  logic [31:0] b_o;
  logic [4:0]  shamt_o;
  logic [4:0]  rd_addr_o;
  logic        reg_write_o;
  logic        illegal_o;
  logic        alu_zero_i;
  logic [31:0] alu_result_i;
  logic        redirect_o;
  logic [31:0] redirect_target_o;

  int n_chk;
  int n_err;

  alu_issue_stage #(.ILLEGAL_AS_NOP(1'b1)) dut (
    .clk               (clk),
    .reset             (reset),
    .instr_valid_i     (instr_valid_i),
    .instr_ready_o     (instr_ready_o),
    .instr_i           (instr_i),
    .pc_plus4_i        (pc_plus4_i),
    .rs_data_i         (rs_data_i),
    .rt_data_i         (rt_data_i),
    .flush_i           (flush_i),
    .ex_valid_o        (ex_valid_o),
    .ex_ready_i        (ex_ready_i),
    .alu_operation_o   (alu_operation_o),
    .a_o               (a_o),
    .b_o               (b_o),
    .shamt_o           (shamt_o),
    .rd_addr_o         (rd_addr_o),
    .reg_write_o       (reg_write_o),
    .illegal_o         (illegal_o),
    .alu_zero_i        (alu_zero_i),
    .alu_result_i      (alu_result_i),
    .redirect_o        (redirect_o),
    .redirect_target_o (redirect_target_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    instr_valid_i = v;
    instr_i       = ins;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    drive(1'b0, 32'h0);
    pc_plus4_i   = 32'h0;
    rs_data_i    = 32'h0;
    rt_data_i    = 32'h0;
    flush_i      = 1'b0;
    ex_ready_i   = 1'b0;
    alu_zero_i   = 1'b0;
    alu_result_i = 32'h0;
    tick();
    tick();
    chk("rst_valid", ex_valid_o, 0);
    chk("rst_redir", redirect_o, 0);
    chk("rst_op", alu_operation_o, 0);
    chk("rst_tgt", redirect_target_o, 0);
    reset = 1'b1;

    // add $3,$1,$2
    drive(1'b1, 32'h00221820);
    rs_data_i  = 32'd5;
    rt_data_i  = 32'd7;
    ex_ready_i = 1'b1;
    #1;
    chk("add_ready", instr_ready_o, 1);
    tick();
    chk("add_valid", ex_valid_o, 1);
    chk("add_op", alu_operation_o, 4'b0011);
    chk("add_a", a_o, 5);
    chk("add_b", b_o, 7);
    chk("add_rd", rd_addr_o, 3);
    chk("add_rw", reg_write_o, 1);
    chk("add_ill", illegal_o, 0);

    // addi / ori / lui immediates
    drive(1'b1, 32'h2024FFFC);
    tick();
    chk("addi_valid", ex_valid_o, 1);
    chk("addi_op", alu_operation_o, 4'b0011);
    chk("addi_b", b_o, 32'hFFFFFFFC);
    chk("addi_rd", rd_addr_o, 4);
    drive(1'b1, 32'h3425FFFC);
    tick();
    chk("ori_op", alu_operation_o, 4'b0110);
    chk("ori_b", b_o, 32'h0000FFFC);
    chk("ori_rd", rd_addr_o, 5);
    drive(1'b1, 32'h3C061234);
    tick();
    chk("lui_op", alu_operation_o, 4'b0010);
    chk("lui_b", b_o, 32'h00001234);
    chk("lui_rw", reg_write_o, 1);

    // beq taken, wrong-path squashed
    drive(1'b1, 32'h10220004);
    pc_plus4_i = 32'h100;
    tick();
    chk("beq_valid", ex_valid_o, 1);
    chk("beq_op", alu_operation_o, 4'b0000);
    chk("beq_rw", reg_write_o, 0);
    alu_zero_i = 1'b1;
    drive(1'b1, 32'h00221820);
    tick();
    chk("beq_redir", redirect_o, 1);
    chk("beq_tgt", redirect_target_o, 32'h110);
    chk("beq_sq1", ex_valid_o, 0);
    chk("beq_rdy", instr_ready_o, 1);
    tick();
    chk("beq_pulse", redirect_o, 0);
    chk("beq_sq2", ex_valid_o, 0);
    chk("beq_hold", redirect_target_o, 32'h110);

    // bne with zero set: not taken
    drive(1'b1, 32'h14220004);
    tick();
    chk("bne_valid", ex_valid_o, 1);
    drive(1'b1, 32'h3425FFFC);
    tick();
    chk("bne_redir", redirect_o, 0);
    chk("bne_next", ex_valid_o, 1);
    chk("bne_next_op", alu_operation_o, 4'b0110);

    // jr $1
    drive(1'b1, 32'h00200008);
    rs_data_i = 32'h00400020;
    tick();
    chk("jr_op", alu_operation_o, 4'b0111);
    chk("jr_a", a_o, 32'h00400020);
    chk("jr_rw", reg_write_o, 0);
    drive(1'b0, 32'h0);
    alu_result_i = 32'h00400020;
    tick();
    chk("jr_redir", redirect_o, 1);
    chk("jr_tgt", redirect_target_o, 32'h00400020);
    chk("jr_valid", ex_valid_o, 0);
    tick();
    chk("jr_pulse", redirect_o, 0);

    // stall then stream without a bubble
    drive(1'b1, 32'h00221820);
    rs_data_i = 32'd5;
    tick();
    chk("stl_cap", ex_valid_o, 1);
    ex_ready_i = 1'b0;
    drive(1'b1, 32'h2024FFFC);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stl_ready", instr_ready_o, 0);
      tick();
      chk("stl_valid", ex_valid_o, 1);
      chk("stl_op", alu_operation_o, 4'b0011);
      chk("stl_b", b_o, 7);
      chk("stl_rd", rd_addr_o, 3);
    end
    ex_ready_i = 1'b1;
    #1;
    chk("stl_rel", instr_ready_o, 1);
    tick();
    chk("str_b1", b_o, 32'hFFFFFFFC);
    chk("str_rd1", rd_addr_o, 4);
    drive(1'b1, 32'h3425FFFC);
    tick();
    chk("str_v2", ex_valid_o, 1);
    chk("str_op2", alu_operation_o, 4'b0110);

    // flush coincident with taken beq fire
    drive(1'b1, 32'h10220004);
    alu_zero_i = 1'b1;
    tick();
    chk("fl_beq", ex_valid_o, 1);
    flush_i = 1'b1;
    drive(1'b1, 32'h00221820);
    tick();
    chk("fl_valid", ex_valid_o, 0);
    chk("fl_redir", redirect_o, 0);
    flush_i = 1'b0;
    drive(1'b0, 32'h0);
    tick();
    chk("fl_redir2", redirect_o, 0);
    chk("fl_valid2", ex_valid_o, 0);

    // illegal encoding issued as a non-writing ADD
    drive(1'b1, 32'hFC000000);
    tick();
    chk("ill_valid", ex_valid_o, 1);
    chk("ill_op", alu_operation_o, 4'b0011);
    chk("ill_flag", illegal_o, 1);
    chk("ill_rw", reg_write_o, 0);

    // async reset in the middle of a stall
    ex_ready_i = 1'b0;
    drive(1'b1, 32'h00221820);
    tick();
    chk("mr_held", ex_valid_o, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_valid", ex_valid_o, 0);
    chk("mr_op", alu_operation_o, 0);
    chk("mr_ill", illegal_o, 0);
    chk("mr_a", a_o, 0);
    chk("mr_redir", redirect_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
